fetch_unit_mt: RTL and testbench

Parametrised multithreaded fetch sequencer that succeeds the fixed 4-thread PC selector. It holds one PC per hardware thread and picks the next enabled thread round-robin. It presents one fetch request per cycle to the I-cache/pre-aligner with a valid/stall handshake. It updates each thread's PC from one of three sources: sequential block increment, front-end predicted-taken target, or back-end mispredict redirect.

---
 rtl/fetch_unit_mt.sv | 85 ++++++++
 tb/tb_fetch_unit_mt.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit_mt.sv
// fetch_unit_mt: round-robin multithreaded fetch sequencer with per-thread PCs and a valid/stall output.
// Define FETCH_PERF_EN to add o_Fetch_Count, a saturating 32-bit accept counter per thread.
module fetch_unit_mt #(
  parameter int ADDRESS_WIDTH = 22,
  parameter int NUM_THREADS = 4,
  parameter int TID_WIDTH = 2,
  parameter int BLOCK_BITS = 3,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0
) (
  input  logic i_Clk,
  input  logic i_Reset_n,
  input  logic i_Stall,
  input  logic [NUM_THREADS-1:0] i_Thread_En,
  input  logic i_Pred_Taken,
  input  logic [ADDRESS_WIDTH-1:0] i_Pred_Target,
  input  logic [NUM_THREADS-1:0] i_Redirect_Valid,
  input  logic [NUM_THREADS*ADDRESS_WIDTH-1:0] i_Redirect_PC,
  output logic o_Valid,
  output logic [ADDRESS_WIDTH-1:0] o_PC,
  output logic [TID_WIDTH-1:0] o_Thread
`ifdef FETCH_PERF_EN
  ,output logic [NUM_THREADS*32-1:0] o_Fetch_Count
`endif
);
  localparam logic [ADDRESS_WIDTH-1:0] BLK = ADDRESS_WIDTH'(1) << BLOCK_BITS;
  logic [ADDRESS_WIDTH-1:0] pc_q [NUM_THREADS];
  logic [ADDRESS_WIDTH-1:0] pc_d [NUM_THREADS];
  logic [ADDRESS_WIDTH-1:0] seq_pc;
  logic [2*NUM_THREADS-1:0] rot;
  logic [TID_WIDTH-1:0] ptr, sel;
  logic found, squash, accept, load;
  // a redirect for the presented thread makes the held fetch stale
  assign squash = o_Valid && i_Redirect_Valid[o_Thread];
  assign accept = o_Valid && !i_Stall && !squash;
  assign load = !o_Valid || !i_Stall || squash;
  assign seq_pc = (pc_q[o_Thread] & ~(BLK - ADDRESS_WIDTH'(1))) + BLK;
  assign rot = {i_Thread_En, i_Thread_En} >> ptr;
  always_comb begin
    for (int t = 0; t < NUM_THREADS; t++)
      pc_d[t] = i_Redirect_Valid[t] ? i_Redirect_PC[t*ADDRESS_WIDTH +: ADDRESS_WIDTH]
              : (accept && o_Thread == TID_WIDTH'(t)) ? (i_Pred_Taken ? i_Pred_Target : seq_pc)
              : pc_q[t];
  end
  // rot[i] is thread (ptr+i) mod N; scanning downward leaves the nearest enabled one
  always_comb begin
    sel = ptr;
    found = 1'b0;
    for (int i = NUM_THREADS; i >= 1; i--)
      if (rot[i]) begin
        sel = TID_WIDTH'(int'(ptr) + i >= NUM_THREADS ? int'(ptr) + i - NUM_THREADS : int'(ptr) + i);
        found = 1'b1;
      end
  end
  always_ff @(posedge i_Clk or negedge i_Reset_n)
    if (!i_Reset_n) begin
      for (int t = 0; t < NUM_THREADS; t++) pc_q[t] <= RESET_PC;
      o_Valid <= 1'b0;
      o_PC <= RESET_PC;
      o_Thread <= '0;
      ptr <= TID_WIDTH'(NUM_THREADS - 1);
    end else begin
      for (int t = 0; t < NUM_THREADS; t++) pc_q[t] <= pc_d[t];
      if (load) begin
        o_Valid <= found;
        if (found) begin
          o_PC <= pc_d[sel];
          o_Thread <= sel;
          ptr <= sel;
        end
      end
    end
`ifdef FETCH_PERF_EN
  logic [31:0] cnt [NUM_THREADS];
  always_ff @(posedge i_Clk or negedge i_Reset_n)
    if (!i_Reset_n) begin
      for (int t = 0; t < NUM_THREADS; t++) cnt[t] <= '0;
    end else begin
      for (int t = 0; t < NUM_THREADS; t++)
        if (accept && o_Thread == TID_WIDTH'(t) && cnt[t] != '1) cnt[t] <= cnt[t] + 32'd1;
    end
  for (genvar g = 0; g < NUM_THREADS; g++) begin : g_cnt
    assign o_Fetch_Count[g*32 +: 32] = cnt[g];
  end
`endif
endmodule

// File: tb/tb_fetch_unit_mt.sv
// tb_fetch_unit_mt: randomized + directed scoreboard bench for fetch_unit_mt against a thread-level reference model.
module tb_fetch_unit_mt;
  localparam int AW = 22, NT = 4, TW = 2, BB = 3;
  logic clk = 0, rst_n = 0, stall = 0, pt = 0;
  logic [NT-1:0] en = '0, rv = '0;
  logic [AW-1:0] tg = '0;
  logic [NT*AW-1:0] rp = '0;
  logic valid;
  logic [AW-1:0] pc;
  logic [TW-1:0] thr;
`ifdef FETCH_PERF_EN
  logic [NT*32-1:0] fcnt;
`endif
  int errors = 0, checks = 0;
  typedef struct packed {logic [AW-1:0] pc; logic [TW-1:0] thr;} fetch_t;
  fetch_t q[$];
  int mpc[NT];
  int mptr, mthr;
  bit mvalid, cur_valid;
  int mcnt[NT];

  always #5 clk = ~clk;

  fetch_unit_mt dut (
    .i_Clk(clk), .i_Reset_n(rst_n), .i_Stall(stall), .i_Thread_En(en),
    .i_Pred_Taken(pt), .i_Pred_Target(tg), .i_Redirect_Valid(rv), .i_Redirect_PC(rp),
    .o_Valid(valid), .o_PC(pc), .o_Thread(thr)
`ifdef FETCH_PERF_EN
    , .o_Fetch_Count(fcnt)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int t = 0; t < NT; t++) begin mpc[t] = 0; mcnt[t] = 0; end
    mptr = NT - 1; mthr = 0; mvalid = 0; cur_valid = 0;
  endtask

  // called once per cycle with that cycle's inputs applied; predicts the next output load
  task automatic model_step();
    int npc[NT];
    int s;
    bit sq, acc, ld;
    cur_valid = mvalid;
    sq = mvalid && rv[mthr];
    acc = mvalid && !stall && !sq;
    ld = !mvalid || !stall || sq;
    for (int t = 0; t < NT; t++) npc[t] = mpc[t];
    if (acc) begin
      npc[mthr] = pt ? int'(tg) : (((mpc[mthr] / (2 ** BB)) + 1) * (2 ** BB)) % (2 ** AW);
      mcnt[mthr]++;
    end
    for (int t = 0; t < NT; t++) if (rv[t]) npc[t] = int'(rp[t*AW +: AW]);
    for (int t = 0; t < NT; t++) mpc[t] = npc[t];
    if (ld) begin
      s = -1;
      for (int k = 1; k <= NT && s < 0; k++) if (en[(mptr + k) % NT]) s = (mptr + k) % NT;
      if (s < 0) mvalid = 0;
      else begin
        mvalid = 1; mthr = s; mptr = s;
        q.push_back('{pc: AW'(mpc[s]), thr: TW'(s)});
      end
    end
  endtask

  task automatic cyc(input bit st, input logic [NT-1:0] e, input bit p, input logic [AW-1:0] t,
                     input logic [NT-1:0] r, input logic [NT*AW-1:0] rpc);
    @(posedge clk); #1;
    rst_n = 1; stall = st; en = e; pt = p; tg = t; rv = r; rp = rpc;
    model_step();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    chk("rst_valid", valid, 0);
    chk("rst_pc", pc, 0);
    chk("rst_thread", thr, 0);
`ifdef FETCH_PERF_EN
    chk("rst_count", fcnt, 0);
`endif
    model_reset();
    q.delete();
  endtask

  function automatic logic [NT*AW-1:0] rpk(input int t, input logic [AW-1:0] v);
    logic [NT*AW-1:0] r;
    r = '0;
    r[t*AW +: AW] = v;
    return r;
  endfunction

  // a fetch transaction ends when it is accepted or squashed
  always @(negedge clk) if (rst_n) begin
    chk("o_Valid", valid, cur_valid);
    if (valid && (!stall || rv[thr])) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard: got fetch pc=%0h thread=%0d required none pending", pc, thr);
      end else begin
        fetch_t f;
        f = q.pop_front();
        chk("o_PC", pc, f.pc);
        chk("o_Thread", thr, f.thr);
      end
    end
  end

  initial begin
    logic [AW-1:0] exp2[4];
    logic [NT*AW-1:0] r;
    exp2 = '{22'h0, 22'h8, 22'h100, 22'h108};
    model_reset();
    do_reset();
    // all threads, free-running
    cyc(0, 4'hF, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 4'hF, 0, 0, 0, 0);
      @(negedge clk);
      chk("rr_thread", thr, i % 4);
      chk("rr_pc", pc, (i / 4) * 8);
    end
    // single thread with a predicted-taken branch
    do_reset();
    cyc(0, 4'b0100, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 4'b0100, i == 1, 22'h100, 0, 0);
      @(negedge clk);
      chk("pred_pc", pc, exp2[i]);
      chk("pred_thread", thr, 2);
    end
    // squash of a stalled fetch
    do_reset();
    cyc(0, 4'hF, 0, 0, 0, 0);
    cyc(0, 4'hF, 0, 0, 0, 0);
    cyc(1, 4'hF, 0, 0, 4'b0010, rpk(1, 22'h2A4));
    cyc(0, 4'hF, 0, 0, 0, 0);
    @(negedge clk);
    chk("squash_thread", thr, 2);
    chk("squash_pc", pc, 0);
    cyc(0, 4'hF, 0, 0, 0, 0);
    cyc(0, 4'hF, 0, 0, 0, 0);
    cyc(0, 4'hF, 0, 0, 0, 0);
    @(negedge clk);
    chk("redir_thread", thr, 1);
    chk("redir_pc", pc, 22'h2A4);
    // redirect beats prediction
    do_reset();
    cyc(0, 4'b0001, 0, 0, 0, 0);
    cyc(0, 4'b0001, 1, 22'h40, 4'b0001, rpk(0, 22'h80));
    cyc(0, 4'b0001, 0, 0, 0, 0);
    @(negedge clk);
    chk("redir_wins", pc, 22'h80);
    // top-block wrap, all disabled, re-enable thread 3
    do_reset();
    cyc(0, 4'b0001, 0, 0, 0, 0);
    cyc(0, 4'b0001, 0, 0, 4'b0001, rpk(0, 22'h3FFFF9));
    cyc(0, 4'b0001, 0, 0, 0, 0);
    @(negedge clk);
    chk("wrap_pre", pc, 22'h3FFFF9);
    cyc(0, 4'b0000, 0, 0, 0, 0);
    @(negedge clk);
    chk("wrap_pc", pc, 0);
    cyc(0, 4'b0000, 0, 0, 0, 0);
    @(negedge clk);
    chk("idle_valid", valid, 0);
    cyc(0, 4'b1000, 0, 0, 0, 0);
    cyc(0, 4'b1000, 0, 0, 0, 0);
    @(negedge clk);
    chk("reenable_thread", thr, 3);
    // ten accepts of thread 1 with one squash
    do_reset();
    cyc(0, 4'b0010, 0, 0, 0, 0);
    for (int i = 0; i < 11; i++)
      cyc(0, 4'b0010, 0, 0, (i == 4) ? 4'b0010 : 4'b0000, rpk(1, 22'h500));
    cyc(1, 4'b0010, 0, 0, 0, 0);
    @(negedge clk);
    chk("model_count1", mcnt[1], 10);
`ifdef FETCH_PERF_EN
    chk("perf_count1", fcnt[63:32], 10);
    chk("perf_count0", fcnt[31:0], mcnt[0]);
`endif
    do_reset();
    // random traffic
    for (int n = 0; n < 600; n++) begin
      r = '0;
      for (int t = 0; t < NT; t++) r[t*AW +: AW] = AW'($urandom);
      cyc($urandom_range(0, 9) < 3, NT'($urandom_range(0, 15)), $urandom_range(0, 3) == 0, AW'($urandom),
          NT'(($urandom_range(0, 7) == 0) ? $urandom_range(1, 15) : 0), r);
    end
    cyc(1, en, 0, 0, 0, 0);
    @(negedge clk);
`ifdef FETCH_PERF_EN
    for (int t = 0; t < NT; t++) chk("perf_random", fcnt[t*32 +: 32], mcnt[t]);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
